// File: rtl/pcie_flr_tracker.sv
// pcie_flr_tracker: tracks PF and VF function-level resets between the HIP and the FLR resync stage,
// forwarding requests, returning completions and self-completing FLRs whose watchdog expires.
//   avl_clk, rst_n              : clock and synchronous active-low reset
//   hip_flr_rcvd_*              : FLR requests from the HIP (PF levels, VF pulse with pf/vf number)
//   flr_rcvd_*                  : requests forwarded to the resync stage
//   fim_flr_completed_*         : completions returned by the resync stage
//   hip_flr_completed_*         : completions to the HIP, including watchdog self-completions
//   flr_timeout/ovf/spurious_err: sticky error flags
//   pending_vf_cnt              : number of occupied VF tracking-table entries
module pcie_flr_tracker #(
    parameter int NUM_PF         = 1,
    parameter int MAX_PENDING    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                               avl_clk,
    input  logic                               rst_n,
    input  logic [7:0]                         hip_flr_rcvd_pf,
    input  logic                               hip_flr_rcvd_vf,
    input  logic [2:0]                         hip_flr_rcvd_pf_num,
    input  logic [10:0]                        hip_flr_rcvd_vf_num,
    output logic [7:0]                         flr_rcvd_pf,
    output logic                               flr_rcvd_vf,
    output logic [2:0]                         flr_rcvd_pf_num,
    output logic [10:0]                        flr_rcvd_vf_num,
    input  logic [7:0]                         fim_flr_completed_pf,
    input  logic                               fim_flr_completed_vf,
    input  logic [2:0]                         fim_flr_completed_pf_num,
    input  logic [10:0]                        fim_flr_completed_vf_num,
    output logic [7:0]                         hip_flr_completed_pf,
    output logic                               hip_flr_completed_vf,
    output logic [2:0]                         hip_flr_completed_pf_num,
    output logic [10:0]                        hip_flr_completed_vf_num,
    output logic                               flr_timeout_err,
    output logic                               flr_ovf_err,
    output logic                               flr_spurious_err,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_vf_cnt
);
    localparam int          CW      = $clog2(MAX_PENDING + 1);
    localparam logic [7:0]  PF_MASK = 8'((1 << NUM_PF) - 1);
    localparam logic [15:0] TMAX    = 16'(TIMEOUT_CYCLES);

    logic [7:0]             pf_m;
    logic [7:0]             pf_lvl_q;
    logic [7:0]             pf_pend_q, pf_pend_d;
    logic [15:0]            pf_timer_q [8];
    logic [15:0]            pf_timer_d [8];
    logic [MAX_PENDING-1:0] ent_valid_q, ent_valid_d;
    logic [2:0]             ent_pf_q [MAX_PENDING];
    logic [2:0]             ent_pf_d [MAX_PENDING];
    logic [10:0]            ent_vf_q [MAX_PENDING];
    logic [10:0]            ent_vf_d [MAX_PENDING];
    logic [15:0]            ent_timer_q [MAX_PENDING];
    logic [15:0]            ent_timer_d [MAX_PENDING];
    logic [7:0]             fwd_pf_q;
    logic                   fwd_vf_q, fwd_vf_d;
    logic [2:0]             fwd_pf_num_q, fwd_pf_num_d;
    logic [10:0]            fwd_vf_num_q, fwd_vf_num_d;
    logic [7:0]             cmpl_pf_q, cmpl_pf_d;
    logic                   cmpl_vf_q, cmpl_vf_d;
    logic [2:0]             cmpl_pf_num_q, cmpl_pf_num_d;
    logic [10:0]            cmpl_vf_num_q, cmpl_vf_num_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   ovf_err_q, ovf_err_d;
    logic                   spurious_err_q, spurious_err_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   vf_hit, vf_dup, vf_placed;

    always_comb begin
        pf_m           = hip_flr_rcvd_pf & PF_MASK;
        pf_pend_d      = pf_pend_q;
        pf_timer_d     = pf_timer_q;
        cmpl_pf_d      = '0;
        timeout_err_d  = timeout_err_q;
        ovf_err_d      = ovf_err_q;
        spurious_err_d = spurious_err_q;
        for (int i = 0; i < 8; i++) begin
            if (pf_pend_q[i]) begin
                // A FIM completion in the expiry cycle wins and is not counted as a timeout.
                if (fim_flr_completed_pf[i] || pf_timer_q[i] == TMAX) begin
                    pf_pend_d[i]  = 1'b0;
                    cmpl_pf_d[i]  = 1'b1;
                    timeout_err_d = timeout_err_d | !fim_flr_completed_pf[i];
                end else begin
                    pf_timer_d[i] = pf_timer_q[i] + 16'd1;
                end
            end else begin
                spurious_err_d = spurious_err_d | fim_flr_completed_pf[i];
                if (pf_m[i] && !pf_lvl_q[i]) begin
                    pf_pend_d[i]  = 1'b1;
                    pf_timer_d[i] = '0;
                end
            end
        end
        ent_valid_d   = ent_valid_q;
        ent_pf_d      = ent_pf_q;
        ent_vf_d      = ent_vf_q;
        ent_timer_d   = ent_timer_q;
        cmpl_vf_d     = 1'b0;
        cmpl_pf_num_d = '0;
        cmpl_vf_num_d = '0;
        fwd_vf_d      = 1'b0;
        fwd_pf_num_d  = '0;
        fwd_vf_num_d  = '0;
        vf_hit        = 1'b0;
        vf_dup        = 1'b0;
        vf_placed     = 1'b0;
        cnt_d         = '0;
        for (int e = 0; e < MAX_PENDING; e++)
            if (ent_valid_q[e] && ent_timer_q[e] != TMAX)
                ent_timer_d[e] = ent_timer_q[e] + 16'd1;
        // Duplicates are never allocated, so a FIM completion matches at most one entry.
        for (int e = 0; e < MAX_PENDING; e++)
            if (fim_flr_completed_vf && ent_valid_q[e] && ent_pf_q[e] == fim_flr_completed_pf_num &&
                ent_vf_q[e] == fim_flr_completed_vf_num) begin
                ent_valid_d[e] = 1'b0;
                vf_hit         = 1'b1;
            end
        if (vf_hit) begin
            cmpl_vf_d     = 1'b1;
            cmpl_pf_num_d = fim_flr_completed_pf_num;
            cmpl_vf_num_d = fim_flr_completed_vf_num;
        end
        spurious_err_d = spurious_err_d | (fim_flr_completed_vf & !vf_hit);
        // One HIP VF completion per cycle; expired entries that lose stay saturated and retry.
        for (int e = 0; e < MAX_PENDING; e++)
            if (!cmpl_vf_d && ent_valid_q[e] && ent_timer_q[e] == TMAX) begin
                ent_valid_d[e] = 1'b0;
                cmpl_vf_d      = 1'b1;
                cmpl_pf_num_d  = ent_pf_q[e];
                cmpl_vf_num_d  = ent_vf_q[e];
                timeout_err_d  = 1'b1;
            end
        // Duplicate and free-slot checks see the table after this cycle's clears.
        for (int e = 0; e < MAX_PENDING; e++)
            if (ent_valid_d[e] && ent_pf_d[e] == hip_flr_rcvd_pf_num && ent_vf_d[e] == hip_flr_rcvd_vf_num)
                vf_dup = 1'b1;
        for (int e = 0; e < MAX_PENDING; e++)
            if (hip_flr_rcvd_vf && !vf_dup && !vf_placed && !ent_valid_d[e]) begin
                ent_valid_d[e] = 1'b1;
                ent_pf_d[e]    = hip_flr_rcvd_pf_num;
                ent_vf_d[e]    = hip_flr_rcvd_vf_num;
                ent_timer_d[e] = '0;
                vf_placed      = 1'b1;
                fwd_vf_d       = 1'b1;
                fwd_pf_num_d   = hip_flr_rcvd_pf_num;
                fwd_vf_num_d   = hip_flr_rcvd_vf_num;
            end
        ovf_err_d = ovf_err_d | (hip_flr_rcvd_vf & !vf_dup & !vf_placed);
        for (int e = 0; e < MAX_PENDING; e++)
            cnt_d = cnt_d + CW'(ent_valid_d[e]);
    end

    always_ff @(posedge avl_clk) begin
        // The level history follows the input even in reset, so levels high at release are not edges.
        pf_lvl_q <= pf_m;
        if (!rst_n) begin
            pf_pend_q      <= '0;
            pf_timer_q     <= '{default: '0};
            ent_valid_q    <= '0;
            ent_pf_q       <= '{default: '0};
            ent_vf_q       <= '{default: '0};
            ent_timer_q    <= '{default: '0};
            fwd_pf_q       <= '0;
            fwd_vf_q       <= 1'b0;
            fwd_pf_num_q   <= '0;
            fwd_vf_num_q   <= '0;
            cmpl_pf_q      <= '0;
            cmpl_vf_q      <= 1'b0;
            cmpl_pf_num_q  <= '0;
            cmpl_vf_num_q  <= '0;
            timeout_err_q  <= 1'b0;
            ovf_err_q      <= 1'b0;
            spurious_err_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            pf_pend_q      <= pf_pend_d;
            pf_timer_q     <= pf_timer_d;
            ent_valid_q    <= ent_valid_d;
            ent_pf_q       <= ent_pf_d;
            ent_vf_q       <= ent_vf_d;
            ent_timer_q    <= ent_timer_d;
            fwd_pf_q       <= pf_m;
            fwd_vf_q       <= fwd_vf_d;
            fwd_pf_num_q   <= fwd_pf_num_d;
            fwd_vf_num_q   <= fwd_vf_num_d;
            cmpl_pf_q      <= cmpl_pf_d;
            cmpl_vf_q      <= cmpl_vf_d;
            cmpl_pf_num_q  <= cmpl_pf_num_d;
            cmpl_vf_num_q  <= cmpl_vf_num_d;
            timeout_err_q  <= timeout_err_d;
            ovf_err_q      <= ovf_err_d;
            spurious_err_q <= spurious_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign flr_rcvd_pf              = fwd_pf_q;
    assign flr_rcvd_vf              = fwd_vf_q;
    assign flr_rcvd_pf_num          = fwd_pf_num_q;
    assign flr_rcvd_vf_num          = fwd_vf_num_q;
    assign hip_flr_completed_pf     = cmpl_pf_q;
    assign hip_flr_completed_vf     = cmpl_vf_q;
    assign hip_flr_completed_pf_num = cmpl_pf_num_q;
    assign hip_flr_completed_vf_num = cmpl_vf_num_q;
    assign flr_timeout_err          = timeout_err_q;
    assign flr_ovf_err              = ovf_err_q;
    assign flr_spurious_err         = spurious_err_q;
    assign pending_vf_cnt           = cnt_q;
endmodule

// File: tb/tb_pcie_flr_tracker.sv
// tb_pcie_flr_tracker: directed scenarios plus randomized traffic on two pcie_flr_tracker instances
// (long and 16-cycle watchdog), each compared every cycle against a behavioural model.
module tb_pcie_flr_tracker;
    logic        avl_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  hip_flr_rcvd_pf;
    logic        hip_flr_rcvd_vf;
    logic [2:0]  hip_flr_rcvd_pf_num;
    logic [10:0] hip_flr_rcvd_vf_num;
    logic [7:0]  fim_flr_completed_pf;
    logic        fim_flr_completed_vf;
    logic [2:0]  fim_flr_completed_pf_num;
    logic [10:0] fim_flr_completed_vf_num;

    logic [7:0]  o_rpf [2];
    logic        o_rvf [2];
    logic [2:0]  o_rpn [2];
    logic [10:0] o_rvn [2];
    logic [7:0]  o_cpf [2];
    logic        o_cvf [2];
    logic [2:0]  o_cpn [2];
    logic [10:0] o_cvn [2];
    logic        o_terr [2];
    logic        o_oerr [2];
    logic        o_serr [2];
    logic [2:0]  o_cnt [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: PF pending flags with start cycle, VF slots with start cycle, sticky errors.
    bit          m_pend [2][8];
    int          m_pstart [2][8];
    bit          m_lvl [2][8];
    bit          m_v [2][4];
    logic [2:0]  m_spf [2][4];
    logic [10:0] m_svf [2][4];
    int          m_sstart [2][4];
    bit          m_terr [2];
    bit          m_oerr [2];
    bit          m_serr [2];
    logic [7:0]  e_rpf [2];
    logic        e_rvf [2];
    logic [2:0]  e_rpn [2];
    logic [10:0] e_rvn [2];
    logic [7:0]  e_cpf [2];
    logic        e_cvf [2];
    logic [2:0]  e_cpn [2];
    logic [10:0] e_cvn [2];
    logic [2:0]  e_cnt [2];

    always #5 avl_clk = ~avl_clk;

    pcie_flr_tracker #(.NUM_PF(2), .MAX_PENDING(4), .TIMEOUT_CYCLES(65535)) dut_a (
        .avl_clk(avl_clk), .rst_n(rst_n),
        .hip_flr_rcvd_pf(hip_flr_rcvd_pf), .hip_flr_rcvd_vf(hip_flr_rcvd_vf),
        .hip_flr_rcvd_pf_num(hip_flr_rcvd_pf_num), .hip_flr_rcvd_vf_num(hip_flr_rcvd_vf_num),
        .flr_rcvd_pf(o_rpf[0]), .flr_rcvd_vf(o_rvf[0]), .flr_rcvd_pf_num(o_rpn[0]), .flr_rcvd_vf_num(o_rvn[0]),
        .fim_flr_completed_pf(fim_flr_completed_pf), .fim_flr_completed_vf(fim_flr_completed_vf),
        .fim_flr_completed_pf_num(fim_flr_completed_pf_num), .fim_flr_completed_vf_num(fim_flr_completed_vf_num),
        .hip_flr_completed_pf(o_cpf[0]), .hip_flr_completed_vf(o_cvf[0]),
        .hip_flr_completed_pf_num(o_cpn[0]), .hip_flr_completed_vf_num(o_cvn[0]),
        .flr_timeout_err(o_terr[0]), .flr_ovf_err(o_oerr[0]), .flr_spurious_err(o_serr[0]),
        .pending_vf_cnt(o_cnt[0])
    );

    pcie_flr_tracker #(.NUM_PF(2), .MAX_PENDING(4), .TIMEOUT_CYCLES(16)) dut_b (
        .avl_clk(avl_clk), .rst_n(rst_n),
        .hip_flr_rcvd_pf(hip_flr_rcvd_pf), .hip_flr_rcvd_vf(hip_flr_rcvd_vf),
        .hip_flr_rcvd_pf_num(hip_flr_rcvd_pf_num), .hip_flr_rcvd_vf_num(hip_flr_rcvd_vf_num),
        .flr_rcvd_pf(o_rpf[1]), .flr_rcvd_vf(o_rvf[1]), .flr_rcvd_pf_num(o_rpn[1]), .flr_rcvd_vf_num(o_rvn[1]),
        .fim_flr_completed_pf(fim_flr_completed_pf), .fim_flr_completed_vf(fim_flr_completed_vf),
        .fim_flr_completed_pf_num(fim_flr_completed_pf_num), .fim_flr_completed_vf_num(fim_flr_completed_vf_num),
        .hip_flr_completed_pf(o_cpf[1]), .hip_flr_completed_vf(o_cvf[1]),
        .hip_flr_completed_pf_num(o_cpn[1]), .hip_flr_completed_vf_num(o_cvn[1]),
        .flr_timeout_err(o_terr[1]), .flr_ovf_err(o_oerr[1]), .flr_spurious_err(o_serr[1]),
        .pending_vf_cnt(o_cnt[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Predicts the outputs produced by the coming clock edge for instance k.
    task automatic model_step(input int k);
        int tm = (k == 1) ? 16 : 65535;
        logic [7:0] pm = hip_flr_rcvd_pf & 8'h03;
        bit done = 0;
        bit dup = 0;
        bit placed = 0;
        int n = 0;
        e_rpf[k] = 8'h00; e_rvf[k] = 1'b0; e_rpn[k] = 3'd0; e_rvn[k] = 11'd0;
        e_cpf[k] = 8'h00; e_cvf[k] = 1'b0; e_cpn[k] = 3'd0; e_cvn[k] = 11'd0;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[k][i] = 0;
                m_lvl[k][i] = pm[i];
            end
            for (int s = 0; s < 4; s++) m_v[k][s] = 0;
            m_terr[k] = 0; m_oerr[k] = 0; m_serr[k] = 0;
            e_cnt[k] = 3'd0;
            return;
        end
        e_rpf[k] = pm;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[k][i]) begin
                if (fim_flr_completed_pf[i]) begin
                    m_pend[k][i] = 0; e_cpf[k][i] = 1'b1;
                end else if (cyc - m_pstart[k][i] > tm) begin
                    m_pend[k][i] = 0; e_cpf[k][i] = 1'b1; m_terr[k] = 1;
                end
            end else begin
                if (fim_flr_completed_pf[i]) m_serr[k] = 1;
                if (pm[i] && !m_lvl[k][i]) begin
                    m_pend[k][i] = 1; m_pstart[k][i] = cyc;
                end
            end
            m_lvl[k][i] = pm[i];
        end
        if (fim_flr_completed_vf) begin
            for (int s = 0; s < 4; s++)
                if (m_v[k][s] && m_spf[k][s] == fim_flr_completed_pf_num && m_svf[k][s] == fim_flr_completed_vf_num) begin
                    m_v[k][s] = 0; done = 1;
                end
            if (done) begin
                e_cvf[k] = 1'b1; e_cpn[k] = fim_flr_completed_pf_num; e_cvn[k] = fim_flr_completed_vf_num;
            end else m_serr[k] = 1;
        end
        for (int s = 0; s < 4; s++)
            if (!done && m_v[k][s] && cyc - m_sstart[k][s] > tm) begin
                m_v[k][s] = 0; done = 1; m_terr[k] = 1;
                e_cvf[k] = 1'b1; e_cpn[k] = m_spf[k][s]; e_cvn[k] = m_svf[k][s];
            end
        if (hip_flr_rcvd_vf) begin
            for (int s = 0; s < 4; s++)
                if (m_v[k][s] && m_spf[k][s] == hip_flr_rcvd_pf_num && m_svf[k][s] == hip_flr_rcvd_vf_num) dup = 1;
            if (!dup) begin
                for (int s = 0; s < 4; s++)
                    if (!placed && !m_v[k][s]) begin
                        m_v[k][s] = 1; m_spf[k][s] = hip_flr_rcvd_pf_num; m_svf[k][s] = hip_flr_rcvd_vf_num;
                        m_sstart[k][s] = cyc; placed = 1;
                        e_rvf[k] = 1'b1; e_rpn[k] = hip_flr_rcvd_pf_num; e_rvn[k] = hip_flr_rcvd_vf_num;
                    end
                if (!placed) m_oerr[k] = 1;
            end
        end
        for (int s = 0; s < 4; s++) n += int'(m_v[k][s]);
        e_cnt[k] = 3'(n);
    endtask

    task automatic cmp(input int k);
        chk("fwd_pf", k, 32'(o_rpf[k]), 32'(e_rpf[k]));
        chk("fwd_vf", k, 32'(o_rvf[k]), 32'(e_rvf[k]));
        if (e_rvf[k]) chk("fwd_num", k, 32'({o_rpn[k], o_rvn[k]}), 32'({e_rpn[k], e_rvn[k]}));
        chk("cmpl_pf", k, 32'(o_cpf[k]), 32'(e_cpf[k]));
        chk("cmpl_vf", k, 32'(o_cvf[k]), 32'(e_cvf[k]));
        if (e_cvf[k]) chk("cmpl_num", k, 32'({o_cpn[k], o_cvn[k]}), 32'({e_cpn[k], e_cvn[k]}));
        chk("errs", k, 32'({o_terr[k], o_oerr[k], o_serr[k]}), 32'({m_terr[k], m_oerr[k], m_serr[k]}));
        chk("cnt", k, 32'(o_cnt[k]), 32'(e_cnt[k]));
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge avl_clk);
        #1;
        cyc++;
        cmp(0);
        cmp(1);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic vf_req(input logic [2:0] p, input logic [10:0] v);
        hip_flr_rcvd_vf = 1'b1; hip_flr_rcvd_pf_num = p; hip_flr_rcvd_vf_num = v;
        step();
        hip_flr_rcvd_vf = 1'b0;
    endtask

    task automatic vf_cmpl(input logic [2:0] p, input logic [10:0] v);
        fim_flr_completed_vf = 1'b1; fim_flr_completed_pf_num = p; fim_flr_completed_vf_num = v;
        step();
        fim_flr_completed_vf = 1'b0;
    endtask

    task automatic pf_cmpl(input logic [7:0] m);
        fim_flr_completed_pf = m;
        step();
        fim_flr_completed_pf = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        for (int k = 0; k < 2; k++)
            chk("reset_outs", k, 32'({o_rvf[k], o_cpf[k], o_cvf[k], o_terr[k], o_oerr[k], o_serr[k], o_cnt[k]}), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        hip_flr_rcvd_pf = 8'h00; hip_flr_rcvd_vf = 1'b0; hip_flr_rcvd_pf_num = 3'd0; hip_flr_rcvd_vf_num = 11'd0;
        fim_flr_completed_pf = 8'h00; fim_flr_completed_vf = 1'b0;
        fim_flr_completed_pf_num = 3'd0; fim_flr_completed_vf_num = 11'd0;
        do_reset();

        // Basic VF request and FIM completion 20 cycles later.
        vf_req(3'd0, 11'd5);
        chk("req_fwd", 0, 32'({o_rvf[0], o_rpn[0], o_rvn[0]}), 32'({1'b1, 3'd0, 11'd5}));
        chk("req_cnt", 0, 32'(o_cnt[0]), 32'd1);
        idle(19);
        vf_cmpl(3'd0, 11'd5);
        chk("cmpl_out", 0, 32'({o_cvf[0], o_cpn[0], o_cvn[0]}), 32'({1'b1, 3'd0, 11'd5}));
        chk("cmpl_cnt", 0, 32'(o_cnt[0]), 32'd0);
        chk("late_spur", 1, 32'(o_serr[1]), 32'd1);

        // Table overflow.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            vf_req(3'd0, 11'(10 + i));
            chk("ovf_fwd", 0, 32'(o_rvf[0]), 32'(i < 4));
        end
        chk("ovf_err", 0, 32'(o_oerr[0]), 32'd1);
        chk("ovf_cnt", 0, 32'(o_cnt[0]), 32'd4);

        // Duplicate request.
        do_reset();
        vf_req(3'd1, 11'd2);
        chk("dup_first", 0, 32'(o_rvf[0]), 32'd1);
        vf_req(3'd1, 11'd2);
        chk("dup_second", 0, 32'(o_rvf[0]), 32'd0);
        chk("dup_cnt", 0, 32'(o_cnt[0]), 32'd1);
        idle(3);
        vf_cmpl(3'd1, 11'd2);
        chk("dup_cmpl", 0, 32'({o_cvf[0], o_cpn[0], o_cvn[0]}), 32'({1'b1, 3'd1, 11'd2}));
        step();
        chk("dup_cmpl_once", 0, 32'(o_cvf[0]), 32'd0);

        // PF watchdog on the 16-cycle instance.
        do_reset();
        hip_flr_rcvd_pf = 8'h01;
        step();
        n = 0;
        do begin
            step();
            n++;
        end while (o_cpf[1] == 8'h00 && n < 40);
        chk("pf_to_delay", 1, 32'(n), 32'd17);
        chk("pf_to_mask", 1, 32'(o_cpf[1]), 32'h01);
        chk("pf_to_err", 1, 32'(o_terr[1]), 32'd1);
        hip_flr_rcvd_pf = 8'h00;
        step();
        pf_cmpl(8'h01);
        chk("pf_late_spur", 1, 32'(o_serr[1]), 32'd1);
        chk("pf_cmpl_ok", 0, 32'({o_cpf[0], o_serr[0]}), 32'({8'h01, 1'b0}));

        // FIM completion collides with a watchdog expiry.
        do_reset();
        vf_req(3'd0, 11'd7);
        idle(5);
        vf_req(3'd0, 11'd3);
        idle(10);
        vf_cmpl(3'd0, 11'd3);
        chk("prio_fim", 1, 32'({o_cvf[1], o_cvn[1], o_terr[1]}), 32'({1'b1, 11'd3, 1'b0}));
        step();
        chk("prio_exp", 1, 32'({o_cvf[1], o_cvn[1], o_terr[1]}), 32'({1'b1, 11'd7, 1'b1}));

        // Reset with entries pending.
        do_reset();
        vf_req(3'd0, 11'd1);
        vf_req(3'd0, 11'd2);
        vf_req(3'd1, 11'd3);
        chk("rst_pre_cnt", 0, 32'(o_cnt[0]), 32'd3);
        do_reset();
        chk("rst_cnt", 0, 32'(o_cnt[0]), 32'd0);
        chk("rst_cnt", 1, 32'(o_cnt[1]), 32'd0);
        vf_cmpl(3'd0, 11'd1);
        chk("rst_stale_cmpl", 0, 32'({o_cvf[0], o_serr[0]}), 32'({1'b0, 1'b1}));
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            step();
            seen += int'(o_cvf[0]) + int'(o_cvf[1]);
        end
        chk("rst_no_cmpl", 1, 32'(seen), 32'd0);

        // PF level already high when reset releases.
        hip_flr_rcvd_pf = 8'h01;
        do_reset();
        seen = 0;
        for (int j = 0; j < 25; j++) begin
            step();
            seen += int'(o_cpf[1] != 8'h00);
        end
        chk("pf_hold_fwd", 1, 32'(o_rpf[1]), 32'h01);
        chk("pf_hold_nocmpl", 1, 32'(seen), 32'd0);
        hip_flr_rcvd_pf = 8'h00;

        // Randomized traffic against the model.
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 15) == 0) hip_flr_rcvd_pf = 8'($urandom_range(0, 7));
            hip_flr_rcvd_vf = ($urandom_range(0, 2) == 0);
            hip_flr_rcvd_pf_num = 3'($urandom_range(0, 1));
            hip_flr_rcvd_vf_num = 11'($urandom_range(0, 3));
            fim_flr_completed_vf = ($urandom_range(0, 3) == 0);
            fim_flr_completed_pf_num = 3'($urandom_range(0, 1));
            fim_flr_completed_vf_num = 11'($urandom_range(0, 3));
            fim_flr_completed_pf = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 7)) : 8'h00;
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        hip_flr_rcvd_vf = 1'b0;
        fim_flr_completed_vf = 1'b0;
        fim_flr_completed_pf = 8'h00;
        rst_n = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
